// File: rtl/gw_ctrl_wan_arbiter.sv
// Round-robin, packet-locked merge of NUM_PORTS WAN control AXI-Stream sources into one stream.
// Output is held in a 2-entry skid buffer; source ready depends only on registered state.
module gw_ctrl_wan_arbiter #(
  parameter int NUM_PORTS        = 4,
  parameter int AXIS_DATA_WIDTH  = 512,
  parameter int AXIS_KEEP_WIDTH  = 64,
  parameter int IP_PORT_WIDTH    = 16,
  parameter int IP_ADDRESS_WIDTH = 32,
  parameter int SEL_WIDTH        = $clog2(NUM_PORTS)
) (
  input  logic                                  i_clk,
  input  logic                                  i_ap_rst_n,
  input  logic [NUM_PORTS-1:0]                  from_src_tvalid,
  output logic [NUM_PORTS-1:0]                  from_src_tready,
  input  logic [NUM_PORTS*AXIS_DATA_WIDTH-1:0]  from_src_tdata,
  input  logic [NUM_PORTS*AXIS_KEEP_WIDTH-1:0]  from_src_tkeep,
  input  logic [NUM_PORTS*IP_PORT_WIDTH-1:0]    from_src_tid,
  input  logic [NUM_PORTS*IP_PORT_WIDTH-1:0]    from_src_tdest,
  input  logic [NUM_PORTS*IP_ADDRESS_WIDTH-1:0] from_src_tuser,
  input  logic [NUM_PORTS-1:0]                  from_src_tlast,
  output logic                                  to_WAN_tvalid,
  input  logic                                  to_WAN_tready,
  output logic [AXIS_DATA_WIDTH-1:0]            to_WAN_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]            to_WAN_tkeep,
  output logic [IP_PORT_WIDTH-1:0]              to_WAN_tid,
  output logic [IP_PORT_WIDTH-1:0]              to_WAN_tdest,
  output logic [IP_ADDRESS_WIDTH-1:0]           to_WAN_tuser,
  output logic                                  to_WAN_tlast,
  output logic [SEL_WIDTH-1:0]                  o_grant_id,
  output logic                                  o_busy
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;

  typedef struct packed {
    logic [AXIS_DATA_WIDTH-1:0]  data;
    logic [AXIS_KEEP_WIDTH-1:0]  keep;
    logic [IP_PORT_WIDTH-1:0]    id;
    logic [IP_PORT_WIDTH-1:0]    dest;
    logic [IP_ADDRESS_WIDTH-1:0] user;
    logic                        last;
  } beat_t;

  logic [1:0]           r_rst_sync;
  logic                 w_rst_n;
  logic [0:0]           r_state;
  logic [SEL_WIDTH-1:0] r_grant;
  beat_t                r_buf [2];
  logic                 r_wr_ptr;
  logic                 r_rd_ptr;
  logic [1:0]           r_count;

  logic [SEL_WIDTH-1:0] w_next_grant;
  logic                 w_any_vld;
  int                   w_idx;
  beat_t                w_in;
  beat_t                w_head;
  logic                 w_src_rdy;
  logic                 w_push;
  logic                 w_pop;

  // Assertion is immediate; release is aligned to i_clk before the core sees it.
  always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
    if (!i_ap_rst_n) r_rst_sync <= 2'b00;
    else             r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  always_comb begin
    w_next_grant = r_grant;
    w_any_vld    = 1'b0;
    w_idx        = 0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      w_idx = (int'(r_grant) + i) % NUM_PORTS;
      if (!w_any_vld && from_src_tvalid[w_idx]) begin
        w_any_vld    = 1'b1;
        w_next_grant = w_idx[SEL_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    w_in.data = from_src_tdata[int'(r_grant)*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
    w_in.keep = from_src_tkeep[int'(r_grant)*AXIS_KEEP_WIDTH +: AXIS_KEEP_WIDTH];
    w_in.id   = from_src_tid[int'(r_grant)*IP_PORT_WIDTH +: IP_PORT_WIDTH];
    w_in.dest = from_src_tdest[int'(r_grant)*IP_PORT_WIDTH +: IP_PORT_WIDTH];
    w_in.user = from_src_tuser[int'(r_grant)*IP_ADDRESS_WIDTH +: IP_ADDRESS_WIDTH];
    w_in.last = from_src_tlast[r_grant];
  end

  // Ready uses only registered occupancy, never the same-cycle pop.
  assign w_src_rdy = (r_state == S_LOCKED) && (r_count != 2'd2);
  assign w_push    = w_src_rdy && from_src_tvalid[r_grant];
  assign w_pop     = to_WAN_tvalid && to_WAN_tready;

  always_comb begin
    from_src_tready = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      from_src_tready[k] = w_src_rdy && (int'(r_grant) == k);
    end
  end

  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= S_IDLE;
      r_grant <= SEL_WIDTH'(NUM_PORTS - 1);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_vld) begin
            r_state <= S_LOCKED;
            r_grant <= w_next_grant;
          end
        end
        default: begin
          if (w_push && w_in.last) r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_buf[0] <= '0;
      r_buf[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_buf[r_wr_ptr] <= w_in;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head        = r_buf[r_rd_ptr];
  assign to_WAN_tvalid = (r_count != 2'd0);
  assign to_WAN_tdata  = w_head.data;
  assign to_WAN_tkeep  = w_head.keep;
  assign to_WAN_tid    = w_head.id;
  assign to_WAN_tdest  = w_head.dest;
  assign to_WAN_tuser  = w_head.user;
  assign to_WAN_tlast  = w_head.last;
  assign o_grant_id    = r_grant;
  assign o_busy        = (r_state == S_LOCKED);

endmodule
